// File: rtl/pipelined_prefix_adder_if.sv
// pipelined_prefix_adder_if: operand/result valid-ready bundle for the pipelined prefix adder
interface pipelined_prefix_adder_if #(parameter int WIDTH = 32);
   logic in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, zero, neg;
   logic [1:0] op;
   logic [WIDTH-1:0] a, b, sum;
   modport master(output in_valid, a, b, op, cin, out_ready, input in_ready, out_valid, sum, cout, ovf, zero, neg);
   modport slave(input in_valid, a, b, op, cin, out_ready, output in_ready, out_valid, sum, cout, ovf, zero, neg);
endinterface

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: Kogge-Stone adder/subtractor with configurable pipeline depth and valid/ready flow
module pipelined_prefix_adder #(
   parameter int WIDTH = 32,
   parameter int PIPE_STAGES = 2
) (
   input logic clk,
   input logic reset,
   pipelined_prefix_adder_if.slave bus
);
   localparam int L = $clog2(WIDTH);
   localparam int S = PIPE_STAGES;
   localparam int NR = (S > 1) ? S - 1 : 1;
   // register k (1..S-1) captures the group generate/propagate after prefix level lvl(k)
   function automatic int lvl(input int k);
      return (k * L) / S;
   endfunction
   function automatic int reg_after(input int j);
      int r;
      r = 0;
      for (int k = 1; k < S; k++) if (lvl(k) == j) r = k;
      return r;
   endfunction
   logic [S-1:0] vld, vin, ld;
   logic [L:0][WIDTH-1:0] gc, pc;
   logic [S-1:0][WIDTH-1:0] sp0;
   logic [S-1:0] sc0;
   logic [NR-1:0][WIDTH-1:0] rg, rp, rp0;
   logic [NR-1:0] rc0;
   logic [WIDTH-1:0] b_cal, sum_n;
   logic [WIDTH:0] c;
   assign b_cal = bus.b ^ {WIDTH{bus.op[0]}};
   assign gc[0] = bus.a & b_cal;
   assign pc[0] = bus.a ^ b_cal;
   assign sp0[0] = pc[0];
   assign sc0[0] = bus.op[1] ? bus.cin : bus.op[0];
   for (genvar j = 1; j <= L; j++) begin : g_lvl
      localparam int R = reg_after(j - 1);
      localparam int D = 1 << (j - 1);
      logic [WIDTH-1:0] gi, pi;
      if (R > 0) begin : g_reg_in
         assign gi = rg[R-1];
         assign pi = rp[R-1];
      end else begin : g_comb_in
         assign gi = gc[j-1];
         assign pi = pc[j-1];
      end
      assign gc[j] = gi | (pi & (gi << D));
      assign pc[j] = pi & ~(~pi << D);
   end
   for (genvar s = 1; s < S; s++) begin : g_seg
      assign sp0[s] = rp0[s-1];
      assign sc0[s] = rc0[s-1];
   end
   always_ff @(posedge clk)
      for (int s = 0; s < S - 1; s++)
         if (ld[s] && vin[s]) begin
            rg[s] <= gc[lvl(s + 1)];
            rp[s] <= pc[lvl(s + 1)];
            rp0[s] <= sp0[s];
            rc0[s] <= sc0[s];
         end
   // after L levels every group spans down to bit 0, so one carry cell per bit folds in c0
   assign c = {gc[L] | (pc[L] & {WIDTH{sc0[S-1]}}), sc0[S-1]};
   assign sum_n = sp0[S-1] ^ c[WIDTH-1:0];
   always_comb begin
      vin = '0;
      ld = '0;
      vin[0] = bus.in_valid;
      for (int s = 1; s < S; s++) vin[s] = vld[s-1];
      for (int s = 0; s < S; s++) ld[s] = bus.out_ready || ((~vld >> s) != '0);
   end
   always_ff @(posedge clk)
      if (reset) vld <= '0;
      else vld <= (ld & vin) | (~ld & vld);
   assign bus.in_ready = ld[0];
   assign bus.out_valid = vld[S-1];
   always_ff @(posedge clk)
      if (reset) {bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg} <= '0;
      else if (ld[S-1] && vin[S-1]) begin
         bus.sum <= sum_n;
         bus.cout <= c[WIDTH];
         bus.ovf <= c[WIDTH] ^ c[WIDTH-1];
         bus.zero <= sum_n == '0;
         bus.neg <= sum_n[WIDTH-1];
      end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: directed and scoreboard-based random checks of two adder configurations
module tb_pipelined_prefix_adder;
   logic clk = 0, reset = 1;
   int checks = 0, errors = 0, rx32 = 0, rx8 = 0;
   logic [67:0] q32[$], q8[$];
   logic [67:0] e32, g32, e8, g8;
   always #5 clk = ~clk;
   pipelined_prefix_adder_if #(.WIDTH(32)) b32();
   pipelined_prefix_adder_if #(.WIDTH(8)) b8();
   pipelined_prefix_adder #(.WIDTH(32), .PIPE_STAGES(2)) dut32(.clk(clk), .reset(reset), .bus(b32.slave));
   pipelined_prefix_adder #(.WIDTH(8), .PIPE_STAGES(1)) dut8(.clk(clk), .reset(reset), .bus(b8.slave));
   function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic cin);
      logic [64:0] m, bc, full;
      logic [63:0] s;
      m = (65'd1 << w) - 65'd1;
      bc = (op[0] ? ~{1'b0, b} : {1'b0, b}) & m;
      full = {1'b0, a} + bc + {64'd0, (op[1] ? cin : op[0])};
      s = full[63:0] & m[63:0];
      return {s == 64'd0, s[w-1], (a[w-1] == bc[w-1]) && (s[w-1] != a[w-1]), full[w], s};
   endfunction
   always @(negedge clk) begin
      if (reset) q32.delete();
      else begin
         if (b32.out_valid && b32.out_ready) begin
            g32 = {b32.zero, b32.neg, b32.ovf, b32.cout, 64'(b32.sum)};
            checks++;
            rx32++;
            if (q32.size() == 0) begin
               errors++;
               $display("FAIL sb32 unexpected result got %h", g32);
            end else begin
               e32 = q32.pop_front();
               if (g32 !== e32) begin
                  errors++;
                  $display("FAIL sb32 result got %h exp %h", g32, e32);
               end
            end
         end
         if (b32.in_valid && b32.in_ready) q32.push_back(model(32, 64'(b32.a), 64'(b32.b), b32.op, b32.cin));
      end
   end
   always @(negedge clk) begin
      if (reset) q8.delete();
      else begin
         if (b8.out_valid && b8.out_ready) begin
            g8 = {b8.zero, b8.neg, b8.ovf, b8.cout, 64'(b8.sum)};
            checks++;
            rx8++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL sb8 unexpected result got %h", g8);
            end else begin
               e8 = q8.pop_front();
               if (g8 !== e8) begin
                  errors++;
                  $display("FAIL sb8 result got %h exp %h", g8, e8);
               end
            end
         end
         if (b8.in_valid && b8.in_ready) q8.push_back(model(8, 64'(b8.a), 64'(b8.b), b8.op, b8.cin));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rand32();
      b32.a = ($urandom_range(7) == 0) ? 32'hFFFFFFFF : ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
      b32.b = ($urandom_range(7) == 0) ? 32'h7FFFFFFF : $urandom;
      b32.op = 2'($urandom);
      b32.cin = 1'($urandom);
   endtask
   task automatic rand8();
      b8.a = 8'($urandom);
      b8.b = 8'($urandom);
      b8.op = 2'($urandom);
      b8.cin = 1'($urandom);
   endtask
   task automatic test_reset();
      reset = 1;
      b32.in_valid = 0; b32.out_ready = 0; b32.a = 0; b32.b = 0; b32.op = 0; b32.cin = 0;
      b8.in_valid = 0; b8.out_ready = 0; b8.a = 0; b8.b = 0; b8.op = 0; b8.cin = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      checks++;
      if ({b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg} !== 37'd0) begin
         errors++;
         $display("FAIL reset32 outputs got %h exp 0", {b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg});
      end
      checks++;
      if ({b8.out_valid, b8.sum, b8.cout, b8.ovf, b8.zero, b8.neg} !== 13'd0) begin
         errors++;
         $display("FAIL reset8 outputs got %h exp 0", {b8.out_valid, b8.sum, b8.cout, b8.ovf, b8.zero, b8.neg});
      end
      checks++;
      if ({b32.in_ready, b8.in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_in_ready got %b exp 11", {b32.in_ready, b8.in_ready});
      end
      b32.out_ready = 1;
      b8.out_ready = 1;
   endtask
   task automatic test_directed();
      logic [31:0] ta[9], tb[9], ts[9];
      logic [1:0] top[9];
      logic tc[9];
      logic [3:0] tf[9];
      ta = '{32'h7FFFFFFF, 32'd5, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd7, 32'h10, 32'd9};
      tb = '{32'd1, 32'd5, 32'd5, 32'd0, 32'd0, 32'd2, 32'd2, 32'h20, 32'd4};
      top = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b01};
      tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ts = '{32'h80000000, 32'd0, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd3, 32'd5, 32'h30, 32'd5};
      tf = '{4'b0101, 4'b1010, 4'b0001, 4'b1010, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
      b32.out_ready = 1;
      for (int i = 0; i < 9; i++) begin
         b32.a = ta[i]; b32.b = tb[i]; b32.op = top[i]; b32.cin = tc[i]; b32.in_valid = 1;
         tick();
         b32.in_valid = 0;
         checks++;
         if (b32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dir%0d early_valid got %b exp 0", i, b32.out_valid);
         end
         tick();
         checks++;
         if ({b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg} !== {1'b1, ts[i], tf[i]}) begin
            errors++;
            $display("FAIL dir%0d result got v=%b s=%h f=%b exp v=1 s=%h f=%b", i, b32.out_valid, b32.sum,
                     {b32.cout, b32.ovf, b32.zero, b32.neg}, ts[i], tf[i]);
         end
         tick();
      end
   endtask
   task automatic test_back_to_back();
      int acc_n = 0, rx0 = rx32;
      b32.out_ready = 1;
      for (int c = 0; c < 8; c++) begin
         rand32();
         b32.in_valid = 1;
         @(negedge clk);
         if (b32.in_ready) acc_n++;
         tick();
      end
      b32.in_valid = 0;
      repeat (3) tick();
      checks++;
      if (acc_n != 8 || rx32 - rx0 != 8) begin
         errors++;
         $display("FAIL back_to_back accepted=%0d delivered=%0d exp 8/8", acc_n, rx32 - rx0);
      end
   endtask
   task automatic test_backpressure();
      int idx = 0, rx0 = rx32;
      logic acc;
      logic [36:0] snap;
      b32.out_ready = 0;
      rand32();
      b32.in_valid = 1;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         if (c == 5) begin
            checks++;
            if (idx != 2 || b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_fill accepted=%0d in_ready=%b out_valid=%b exp 2/0/1", idx, b32.in_ready, b32.out_valid);
            end
            snap = {b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg};
            repeat (2) tick();
            checks++;
            if ({b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg} !== snap) begin
               errors++;
               $display("FAIL bp_stable got %h exp %h", {b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg}, snap);
            end
            b32.out_ready = 1;
         end
         @(negedge clk);
         acc = b32.in_valid && b32.in_ready;
         tick();
         if (acc) begin
            idx++;
            if (idx < 6) rand32();
            else b32.in_valid = 0;
         end
      end
      for (int c = 0; c < 10 && rx32 - rx0 != 6; c++) tick();
      checks++;
      if (idx != 6 || rx32 - rx0 != 6) begin
         errors++;
         $display("FAIL bp_drain accepted=%0d delivered=%0d exp 6/6", idx, rx32 - rx0);
      end
      b32.in_valid = 0;
   endtask
   task automatic test_reset_midstream();
      int rx0;
      logic stale = 0;
      b32.out_ready = 0;
      b32.a = 32'h1234; b32.b = 32'h1111; b32.op = 0; b32.cin = 0; b32.in_valid = 1;
      tick();
      b32.a = 32'h4321;
      tick();
      b32.in_valid = 0;
      checks++;
      if (b32.out_valid !== 1'b1 || b32.sum !== 32'h2345) begin
         errors++;
         $display("FAIL mid_prefill got v=%b s=%h exp v=1 s=00002345", b32.out_valid, b32.sum);
      end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg} !== 37'd0) begin
         errors++;
         $display("FAIL mid_reset32 got %h exp 0", {b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero, b32.neg});
      end
      checks++;
      if ({b8.out_valid, b8.sum, b8.cout, b8.ovf, b8.zero, b8.neg} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset8 got %h exp 0", {b8.out_valid, b8.sum, b8.cout, b8.ovf, b8.zero, b8.neg});
      end
      b32.out_ready = 1;
      rx0 = rx32;
      repeat (6) begin
         tick();
         if (b32.out_valid !== 1'b0) stale = 1;
      end
      checks++;
      if (stale || rx32 != rx0) begin
         errors++;
         $display("FAIL mid_stale got stale=%b delivered=%0d exp 0/0", stale, rx32 - rx0);
      end
   endtask
   task automatic test_w8();
      int n = 0;
      logic acc;
      b8.out_ready = 1;
      b8.a = 8'h80; b8.b = 8'h01; b8.op = 2'b01; b8.cin = 0; b8.in_valid = 1;
      checks++;
      if (b8.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL w8_idle got out_valid=%b exp 0", b8.out_valid);
      end
      tick();
      b8.in_valid = 0;
      checks++;
      if ({b8.out_valid, b8.sum, b8.cout, b8.ovf, b8.zero, b8.neg} !== {1'b1, 8'h7F, 4'b1100}) begin
         errors++;
         $display("FAIL w8_sub got v=%b s=%h f=%b exp v=1 s=7f f=1100", b8.out_valid, b8.sum, {b8.cout, b8.ovf, b8.zero, b8.neg});
      end
      tick();
      b8.out_ready = 0;
      b8.a = 8'h11; b8.b = 8'h22; b8.op = 0; b8.in_valid = 1;
      repeat (3) begin
         @(negedge clk);
         acc = b8.in_valid && b8.in_ready;
         tick();
         if (acc) begin
            n++;
            b8.a = 8'h33;
         end
      end
      checks++;
      if (n != 1 || b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1 || b8.sum !== 8'h33) begin
         errors++;
         $display("FAIL w8_bp accepted=%0d in_ready=%b v=%b s=%h exp 1/0/1/33", n, b8.in_ready, b8.out_valid, b8.sum);
      end
      b8.out_ready = 1;
      tick();
      b8.in_valid = 0;
      tick();
   endtask
   task automatic test_random();
      int s32 = 0, s8 = 0, cyc = 0, r32 = rx32, r8 = rx8;
      logic a32, a8;
      b32.in_valid = 0;
      b8.in_valid = 0;
      while ((s32 < 10000 || s8 < 10000 || q32.size() != 0 || q8.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         a32 = b32.in_valid && b32.in_ready;
         a8 = b8.in_valid && b8.in_ready;
         tick();
         cyc++;
         if (a32) s32++;
         if (a8) s8++;
         if (!b32.in_valid || a32) begin
            b32.in_valid = (s32 < 10000) && ($urandom_range(3) != 0);
            rand32();
         end
         if (!b8.in_valid || a8) begin
            b8.in_valid = (s8 < 10000) && ($urandom_range(3) != 0);
            rand8();
         end
         b32.out_ready = (s32 >= 10000) || ($urandom_range(3) != 0);
         b8.out_ready = (s8 >= 10000) || ($urandom_range(3) != 0);
      end
      checks++;
      if (rx32 - r32 != 10000 || q32.size() != 0) begin
         errors++;
         $display("FAIL rand32 delivered=%0d pending=%0d exp 10000/0", rx32 - r32, q32.size());
      end
      checks++;
      if (rx8 - r8 != 10000 || q8.size() != 0) begin
         errors++;
         $display("FAIL rand8 delivered=%0d pending=%0d exp 10000/0", rx8 - r8, q8.size());
      end
   endtask
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_w8();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_prefix_adder.md
# pipelined_prefix_adder

Parametrised, pipelined parallel-prefix adder/subtractor: the successor to the 32-bit combinational prefix adder. It adds configurable width, configurable pipeline depth, carry-in chaining modes, result flags and a valid/ready handshake with backpressure. It sits between the ALU operand-select stage and the writeback/flag register logic of the CPU datapath.

## Interface

- WIDTH, 32, operand and result width in bits; any value >= 2.
- PIPE_STAGES, 2, register stages from accepted input to output; legal range 1 to L+1, where L = ceil(log2(WIDTH)) prefix levels.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow.
- cin  input  1  carry-in for op 1x; 1 means "no borrow" for op 11.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtraction, 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

## Operation

- Operand transform: b_cal = b XOR {WIDTH{op[0]}}.
- Effective carry-in c0 is 0 for op 00, 1 for op 01, and cin for op 10 and op 11.
- Result: {cout, sum} = a + b_cal + c0, computed modulo 2^(WIDTH+1).
- Prefix network:
  - Input cells: p = a^b_cal, g = a&b_cal.
  - L Kogge-Stone black-cell levels; level j combines span 2^(j-1).
  - Carry cells fold in c0.
  - Sum cells: sum[i] = p[i] ^ c[i].
- Flags:
  - ovf = carry into MSB XOR cout.
  - zero and neg are computed from the final sum.
- Pipeline register placement:
  - Registers 1..PIPE_STAGES-1 sit after prefix level floor(k*L/PIPE_STAGES), for k = 1..PIPE_STAGES-1.
  - The final register always holds sum and the flags.
  - Each stage carries a valid bit.
  - op, c0 and p travel with the data as needed.
- Flow control:
  - Stage k loads when it is empty or stage k+1 loads in the same cycle.
  - The last stage loads when it is empty or out_ready=1.
  - in_ready equals the stage-1 load condition. It may depend combinationally on out_ready; the chain is not cut.
  - A beat is accepted when in_valid & in_ready, and transfers out when out_valid & out_ready.
  - When not loaded, a stage holds its contents.
  - Results leave in acceptance order. None is dropped or duplicated.
- Reset:
  - All valid bits, sum and all flags clear to 0; out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - In-flight beats are discarded; reset asserted mid-stream wins over all loads.
- While out_valid=1 and out_ready=0, sum and the flags stay stable.

## Timing

- Latency: a beat accepted at edge N gives out_valid=1 after edge N+PIPE_STAGES-1. It is visible in the cycle following that edge, with PIPE_STAGES registered stages in total.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: with out_ready held 0, exactly PIPE_STAGES beats are accepted, then in_ready=0.
- Simultaneous in and out on a full pipe with out_ready=1: both transfers occur in the same cycle and occupancy is unchanged.
- The critical path per stage is bounded by ceil(L/PIPE_STAGES)+1 cell levels.
- in_valid with in_ready=0: the beat is not taken; the source holds it.

## Test plan

- WIDTH=32, PIPE_STAGES=2: add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, neg=1, cout=0, zero=0; out_valid exactly 2 cycles after acceptance.
- Subtraction:
  - sub 5-5 -> sum=0, zero=1, cout=1, ovf=0.
  - sub 3-5 -> sum=0xFFFFFFFE, cout=0, neg=1.
- Chaining:
  - op 10, a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, zero=1.
  - op 11, a=0, b=0, cin=0 -> sum=0xFFFFFFFF, cout=0.
- Backpressure:
  - Stream 6 beats with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted.
  - Then out_ready=1 -> all 6 results emerge in order, and outputs are stable while stalled.
- Reset mid-stream: 2 beats in flight, reset for 1 cycle -> out_valid=0 and sum and flags = 0 next cycle; no stale result appears afterwards.
- WIDTH=8, PIPE_STAGES=1: sub 0x80-0x01 -> sum=0x7F, ovf=1, cout=1; 1-cycle latency. Plus 10k random beats per config against a reference model with random out_ready.
